lsu_mem_stage: RTL and testbench

- Memory-stage load/store unit directly downstream of the ALU in the RV32I core.
- Takes the ALU result as the effective address (rs1+imm) or as a pass-through result, and drives the data-memory req/gnt/rvalid handshake.
- Performs byte-lane steering and sign/zero extension, and presents one registered writeback record per accepted op.
- Stalls the EX stage via ex_ready while a memory transaction is outstanding.

---
 rtl/lsu_mem_stage_if.sv | 45 ++++
 rtl/lsu_mem_stage.sv | 150 +++++++++++++++
 tb/tb_lsu_mem_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_if.sv
// Bundles the EX-side op handshake, the data-memory bus and the writeback record.
// The master view is the LSU itself; the slave view is the EX stage, memory and writeback.
interface lsu_mem_stage_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_ready;
    logic            ex_is_load;
    logic            ex_is_store;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_alu_out;
    logic [XLEN-1:0] ex_store_data;
    logic [4:0]      ex_rd;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    logic            wb_valid;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_err;

    modport master (
        input  ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_alu_out, ex_store_data, ex_rd,
        output ex_ready,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output wb_valid, wb_we, wb_rd, wb_data, wb_err
    );

    modport slave (
        output ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_alu_out, ex_store_data, ex_rd,
        input  ex_ready,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  wb_valid, wb_we, wb_rd, wb_data, wb_err
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV32I memory-stage load/store unit: legality check, lane steering, one
// outstanding dmem transaction, sign/zero extension and a registered writeback record.
module lsu_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           reset,
    lsu_mem_stage_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

    state_t     state;
    logic [2:0] funct3_p1;
    logic [1:0] off_p1;
    logic [4:0] rd_p1;
    logic       is_load_p1;

    function automatic logic access_ok(input logic ld, input logic st,
                                       input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (!(ld && st)) begin
            case (f3)
                3'b000:  ok = 1'b1;
                3'b001:  ok = !off[0];
                3'b010:  ok = (off == 2'b00);
                3'b100:  ok = ld;
                3'b101:  ok = ld && !off[0];
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  return 4'b0001 << off;
            3'b001:  return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3, input logic [XLEN-1:0] rs2);
        case (f3)
            3'b000:  return {4{rs2[7:0]}};
            3'b001:  return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                    input logic [XLEN-1:0] word);
        logic [XLEN-1:0]    lane;
        logic signed [7:0]  lane_b;
        logic signed [15:0] lane_h;
        lane   = word >> {off, 3'b000};
        lane_b = lane[7:0];
        lane_h = lane[15:0];
        case (f3)
            3'b000:  return XLEN'(lane_b);
            3'b001:  return XLEN'(lane_h);
            3'b100:  return XLEN'(lane[7:0]);
            3'b101:  return XLEN'(lane[15:0]);
            default: return lane;
        endcase
    endfunction

    // Gating with reset keeps EX from seeing a ready LSU while it is held in reset.
    assign bus.ex_ready = (state == IDLE) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            funct3_p1      <= '0;
            off_p1         <= '0;
            rd_p1          <= '0;
            is_load_p1     <= 1'b0;
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_wdata <= '0;
            bus.dmem_be    <= '0;
            bus.wb_valid   <= 1'b0;
            bus.wb_we      <= 1'b0;
            bus.wb_rd      <= '0;
            bus.wb_data    <= '0;
            bus.wb_err     <= 1'b0;
        end else begin
            bus.wb_valid <= 1'b0;
            bus.wb_we    <= 1'b0;
            bus.wb_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ex_valid) begin
                        if (!bus.ex_is_load && !bus.ex_is_store) begin
                            bus.wb_valid <= 1'b1;
                            bus.wb_we    <= 1'b1;
                            bus.wb_rd    <= bus.ex_rd;
                            bus.wb_data  <= bus.ex_alu_out;
                        end else if (!access_ok(bus.ex_is_load, bus.ex_is_store,
                                                bus.ex_funct3, bus.ex_alu_out[1:0])) begin
                            bus.wb_valid <= 1'b1;
                            bus.wb_err   <= 1'b1;
                            bus.wb_rd    <= bus.ex_rd;
                            bus.wb_data  <= '0;
                        end else begin
                            funct3_p1      <= bus.ex_funct3;
                            off_p1         <= bus.ex_alu_out[1:0];
                            rd_p1          <= bus.ex_rd;
                            is_load_p1     <= bus.ex_is_load;
                            bus.dmem_req   <= 1'b1;
                            bus.dmem_we    <= bus.ex_is_store;
                            bus.dmem_addr  <= {bus.ex_alu_out[XLEN-1:2], 2'b00};
                            bus.dmem_wdata <= bus.ex_is_store ?
                                              store_wdata(bus.ex_funct3, bus.ex_store_data) : '0;
                            bus.dmem_be    <= bus.ex_is_store ?
                                              store_be(bus.ex_funct3, bus.ex_alu_out[1:0]) : 4'b1111;
                            state          <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.dmem_gnt) begin
                        bus.dmem_req <= 1'b0;
                        if (is_load_p1) begin
                            state <= WAIT_RSP;
                        end else begin
                            bus.wb_valid <= 1'b1;
                            bus.wb_rd    <= rd_p1;
                            bus.wb_data  <= '0;
                            state        <= IDLE;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (bus.dmem_rvalid) begin
                        bus.wb_valid <= 1'b1;
                        bus.wb_we    <= 1'b1;
                        bus.wb_rd    <= rd_p1;
                        bus.wb_data  <= load_extend(funct3_p1, off_p1, bus.dmem_rdata);
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed-vector bench for lsu_mem_stage with hand-computed expectations.
module tb_lsu_mem_stage;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lsu_mem_stage_if #(.XLEN(32)) bus ();

    lsu_mem_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ex_valid      = 1'b0;
        bus.ex_is_load    = 1'b0;
        bus.ex_is_store   = 1'b0;
        bus.ex_funct3     = 3'b000;
        bus.ex_alu_out    = '0;
        bus.ex_store_data = '0;
        bus.ex_rd         = '0;
        bus.dmem_gnt      = 1'b0;
        bus.dmem_rvalid   = 1'b0;
        bus.dmem_rdata    = '0;
    endtask

    task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd);
        bus.ex_valid      = 1'b1;
        bus.ex_is_load    = ld;
        bus.ex_is_store   = st;
        bus.ex_funct3     = f3;
        bus.ex_alu_out    = addr;
        bus.ex_store_data = sdata;
        bus.ex_rd         = rd;
    endtask

    // Load with gnt in the first REQ cycle and rvalid after rv_wait idle cycles.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [4:0] rd,
                           input int rv_wait, input logic [31:0] exp);
        present(1'b1, 1'b0, f3, addr, 32'h0, rd);
        step();
        idle_inputs();
        chk({tag, "_req"},  32'(bus.dmem_req), 32'd1);
        chk({tag, "_addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
        chk({tag, "_be"},   32'(bus.dmem_be), 32'hF);
        chk({tag, "_we"},   32'(bus.dmem_we), 32'd0);
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0;
        chk({tag, "_req_drop"}, 32'(bus.dmem_req), 32'd0);
        for (int i = 0; i < rv_wait; i++) begin
            chk({tag, "_nowb"}, 32'(bus.wb_valid), 32'd0);
            step();
        end
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = rdata;
        step();
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = '0;
        chk({tag, "_wbv"},  32'(bus.wb_valid), 32'd1);
        chk({tag, "_wbwe"}, 32'(bus.wb_we), 32'd1);
        chk({tag, "_rd"},   32'(bus.wb_rd), 32'(rd));
        chk({tag, "_data"}, bus.wb_data, exp);
        chk({tag, "_err"},  32'(bus.wb_err), 32'd0);
        step();
        chk({tag, "_pulse"}, 32'(bus.wb_valid), 32'd0);
    endtask

    task automatic expect_err(input string tag, input logic ld, input logic st,
                              input logic [2:0] f3, input logic [31:0] addr);
        present(ld, st, f3, addr, 32'hFFFF_FFFF, 5'd9);
        step();
        idle_inputs();
        chk({tag, "_wbv"},  32'(bus.wb_valid), 32'd1);
        chk({tag, "_err"},  32'(bus.wb_err), 32'd1);
        chk({tag, "_wbwe"}, 32'(bus.wb_we), 32'd0);
        chk({tag, "_data"}, bus.wb_data, 32'h0);
        chk({tag, "_noreq"}, 32'(bus.dmem_req), 32'd0);
        step();
        chk({tag, "_clr"}, 32'(bus.wb_err), 32'd0);
    endtask

    task automatic store_steer(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] rs2, input logic [31:0] exp_wd, input logic [3:0] exp_be);
        present(1'b0, 1'b1, f3, addr, rs2, 5'd3);
        step();
        idle_inputs();
        chk({tag, "_wd"}, bus.dmem_wdata, exp_wd);
        chk({tag, "_be"}, 32'(bus.dmem_be), 32'(exp_be));
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0;
        chk({tag, "_wbv"}, 32'(bus.wb_valid), 32'd1);
    endtask

    initial begin
        idle_inputs();
        // Hold reset with an op presented: nothing must come out.
        present(1'b0, 1'b0, 3'b000, 32'h0000_0777, 32'h0, 5'd1);
        step();
        step();
        chk("rst_ready", 32'(bus.ex_ready), 32'd0);
        chk("rst_req",   32'(bus.dmem_req), 32'd0);
        chk("rst_wbv",   32'(bus.wb_valid), 32'd0);
        chk("rst_data",  bus.wb_data, 32'h0);
        idle_inputs();
        reset = 1'b0;
        step();
        chk("idle_ready", 32'(bus.ex_ready), 32'd1);

        // Pass-through
        present(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
        step();
        idle_inputs();
        chk("pt_wbv",   32'(bus.wb_valid), 32'd1);
        chk("pt_wbwe",  32'(bus.wb_we), 32'd1);
        chk("pt_rd",    32'(bus.wb_rd), 32'd5);
        chk("pt_data",  bus.wb_data, 32'h0000_1234);
        chk("pt_noreq", 32'(bus.dmem_req), 32'd0);
        step();
        chk("pt_pulse", 32'(bus.wb_valid), 32'd0);

        // Store byte at 0x1003 with gnt withheld for two cycles
        present(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 5'd2);
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            chk("sb_req",   32'(bus.dmem_req), 32'd1);
            chk("sb_we",    32'(bus.dmem_we), 32'd1);
            chk("sb_addr",  bus.dmem_addr, 32'h0000_1000);
            chk("sb_be",    32'(bus.dmem_be), 32'h8);
            chk("sb_wd",    bus.dmem_wdata, 32'hABAB_ABAB);
            chk("sb_ready", 32'(bus.ex_ready), 32'd0);
            if (i == 2) bus.dmem_gnt = 1'b1;
            step();
        end
        bus.dmem_gnt = 1'b0;
        chk("sb_wbv",   32'(bus.wb_valid), 32'd1);
        chk("sb_wbwe",  32'(bus.wb_we), 32'd0);
        chk("sb_reqlo", 32'(bus.dmem_req), 32'd0);
        chk("sb_ready2", 32'(bus.ex_ready), 32'd1);
        // Accept a new op in the same cycle the store's wb_valid is high
        present(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd7);
        step();
        idle_inputs();
        chk("b2b_wbv",  32'(bus.wb_valid), 32'd1);
        chk("b2b_data", bus.wb_data, 32'h0000_0055);
        chk("b2b_rd",   32'(bus.wb_rd), 32'd7);
        step();

        store_steer("sh", 3'b001, 32'h0000_1002, 32'h1234_CAFE, 32'hCAFE_CAFE, 4'b1100);
        step();
        store_steer("sw", 3'b010, 32'h0000_1004, 32'h1234_CAFE, 32'h1234_CAFE, 4'b1111);
        step();

        do_load("lb",  3'b000, 32'h0000_2002, 32'h0080_0000, 5'd10, 0, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h0000_2002, 32'h0080_0000, 5'd11, 0, 32'h0000_0080);
        do_load("lh",  3'b001, 32'h0000_2002, 32'h8001_0000, 5'd12, 0, 32'hFFFF_8001);
        do_load("lhu", 3'b101, 32'h0000_2002, 32'h8001_0000, 5'd13, 0, 32'h0000_8001);
        do_load("lw",  3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 5'd14, 0, 32'hDEAD_BEEF);
        do_load("lwd", 3'b010, 32'h0000_3004, 32'h1357_9BDF, 5'd15, 2, 32'h1357_9BDF);
        do_load("lb3", 3'b000, 32'h0000_2003, 32'h7F00_0000, 5'd16, 0, 32'h0000_007F);

        expect_err("mis_lw", 1'b1, 1'b0, 3'b010, 32'h0000_2002);
        expect_err("mis_lh", 1'b1, 1'b0, 3'b001, 32'h0000_2001);
        expect_err("st_bu",  1'b0, 1'b1, 3'b100, 32'h0000_2000);
        expect_err("ld_st",  1'b1, 1'b1, 3'b010, 32'h0000_2000);
        expect_err("ld_f3",  1'b1, 1'b0, 3'b011, 32'h0000_2000);

        // Reset while in REQ: dmem_req must drop without a clock edge
        present(1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'h1111_2222, 5'd4);
        step();
        idle_inputs();
        chk("rq_req_pre", 32'(bus.dmem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rq_req_rst", 32'(bus.dmem_req), 32'd0);
        chk("rq_be_rst",  32'(bus.dmem_be), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Reset while in WAIT_RSP, then a stray rvalid
        present(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd6);
        step();
        idle_inputs();
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0;
        chk("wr_ready", 32'(bus.ex_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("wr_req",   32'(bus.dmem_req), 32'd0);
        chk("wr_addr",  bus.dmem_addr, 32'h0);
        chk("wr_wbv",   32'(bus.wb_valid), 32'd0);
        chk("wr_wbrd",  32'(bus.wb_rd), 32'd0);
        chk("wr_ready2", 32'(bus.ex_ready), 32'd0);
        step();
        reset = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hBAD0_BAD0;
        step();
        bus.dmem_rvalid = 1'b0;
        chk("stray_wbv",  32'(bus.wb_valid), 32'd0);
        chk("stray_data", bus.wb_data, 32'h0);
        step();
        chk("stray_wbv2", 32'(bus.wb_valid), 32'd0);
        chk("post_ready", 32'(bus.ex_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
